cpu_divider_radix: RTL
======================

// Module: cpu_divider_radix
// PURPOSE
//  Parametrised iterative integer divider for the CPU execute stage; accepts ops from p3.
//  Retires BITS_PER_CYCLE quotient bits per clock.
//  Handles signed/unsigned operands internally and returns quotient or remainder.
//  Defines divide-by-zero and signed-overflow results.
//  Result is held until the pipeline accepts it (valid/ack); op can be aborted by a pipeline flush.
// PARAMETERS
//  WIDTH           32  operand/result width in bits
//  BITS_PER_CYCLE  2   quotient bits per iteration; legal 1,2,4; WIDTH % BITS_PER_CYCLE == 0
//  DEST_W          5   width of latent destination register tag
// PORTS
//  clock           in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  div_ready       out  1       idle, can accept p3_div_start this cycle
//  p3_div_start    in   1       start pulse; honoured only when div_ready=1
//  p3_numerator    in   WIDTH   dividend
//  p3_denominator  in   WIDTH   divisor
//  p3_div_signed   in   1       1=operands two's complement
//  p3_div_mod      in   1       0=return quotient, 1=return remainder
//  p3_latent_dest  in   DEST_W  destination tag, returned with result
//  div_abort       in   1       pipeline flush; kills op in flight or held result
//  div_valid       out  1       div_result/div_dest_reg valid; held until div_ack
//  div_ack         in   1       pipeline accepted result this cycle (qualified by div_valid)
//  div_result      out  WIDTH   quotient or remainder
//  div_dest_reg    out  DEST_W  tag captured at start
// BEHAVIOUR
//  Reset: state IDLE; div_ready=1, div_valid=0, div_result=0, div_dest_reg=0; all working regs cleared.
//  State machine:
//   IDLE  -> CALC on start when denom!=0 and not signed-overflow.
//   IDLE  -> FIXUP on start for the special cases below.
//   CALC  -> FIXUP after ITER=WIDTH/BITS_PER_CYCLE cycles.
//   FIXUP -> DONE after 1 cycle.
//   DONE  -> IDLE on div_ack.
//  Outputs by state: div_ready=1 only in IDLE; div_valid=1 only in DONE.
//  Start capture: abs values of operands when signed (MIN stays MIN as unsigned magnitude).
//   q_neg = signed & (n_msb ^ d_msb); r_neg = signed & n_msb; tag and mod flag latched.
//  CALC step: BITS_PER_CYCLE chained restoring stages.
//   each stage: rem' = {rem[W-2:0], next numerator bit}; trial = rem' - denom (WIDTH+1 bits);
//   trial >= 0 -> rem=trial, q bit=1; else rem=rem', q bit=0. Numerator bits consumed MSB first.
//  FIXUP: result = mod ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo); registered into div_result.
//  Latency: start sampled at edge N; div_valid high after edge N+ITER+1.
//   BITS_PER_CYCLE=1/2/4 at WIDTH=32 -> 33/17/9 cycles.
//  Special cases (FIXUP directly, div_valid after edge N+1):
//   denom==0   -> quotient all-ones, remainder = numerator (raw, unsigned interpretation).
//   signed MIN / -1 -> quotient MIN, remainder 0.
//  Handshake: in DONE, div_result/div_dest_reg stable until div_ack.
//   ack and new start cannot coincide (ready low in DONE); next start earliest the cycle after ack.
//  Start while div_ready=0: ignored, no state change (assertion flags it).
//  div_abort: any state -> IDLE next edge; div_valid drops next edge; no result ever produced for the op.
//   abort+start same cycle: abort wins, start dropped.
//   abort+ack same cycle in DONE: IDLE, identical outcome.
//  Reset mid-op: same as abort plus register clear; reset dominates all inputs.
//  div_result is 0 outside DONE (no X propagation into writeback mux).
// STRUCTURE
//  cpu_div_pkg: typedef enum logic [1:0] {DIV_IDLE,DIV_CALC,DIV_FIXUP,DIV_DONE} div_state_t;
//   function div_abs(); localparam ITER computation helper.
//  Sub-module cpu_div_stage (combinational, one restoring step, WIDTH param).
//   BITS_PER_CYCLE instances chained via generate.
//  Top: FSM, iteration counter ($clog2(ITER) bits, counts down), operand/rem/quo regs, fixup register.
// TESTING
//  Unsigned 100/7, mod=0 then mod=1 -> 14 (0x0E), 2; tag 5'd9 echoed on div_dest_reg.
//  Signed -7/2 -> 0xFFFFFFFD (-3); mod -> 0xFFFFFFFF (-1); 7/-2 mod -> 1.
//  5/0 unsigned -> 0xFFFFFFFF, mod -> 5; signed 0x80000000/0xFFFFFFFF -> 0x80000000, mod -> 0; valid at N+1.
//  Latency sweep BITS_PER_CYCLE=1,2,4 with 0xFFFFFFFF/1 -> valid at 33,17,9 cycles, result 0xFFFFFFFF.
//  Backpressure: ack low 10 cycles -> valid/result/tag stable, ready=0.
//   start pulses in that window ignored; ack -> ready next cycle.
//  div_abort at CALC cycle 5 (also with start same cycle) -> div_valid never rises, ready next cycle;
//   following 100/7 returns 14.

Source files
------------

// File: rtl/cpu_div_pkg.sv
// ---------------------------------------------------------------------------
// cpu_div_pkg
// Shared types and helpers for the iterative radix divider.
//   div_state_t : divider FSM state encoding
//   div_abs     : conditional two's complement negate (used for operand
//                 magnitudes and for the sign fix-up of the result)
//   div_iter    : number of CALC iterations for a width / bits-per-cycle pair
//   div_cnt_w   : iteration counter width, never less than 1 bit
// ---------------------------------------------------------------------------
package cpu_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIXUP,
        DIV_DONE
    } div_state_t;

    // Widest operand div_abs can handle; callers zero-extend into it and
    // truncate the result back, which keeps the low bits of the negation exact.
    localparam int DIV_ABS_W = 64;

    // Negate when neg is set. The most negative value maps onto itself,
    // which reads back correctly as an unsigned magnitude.
    function automatic logic [DIV_ABS_W-1:0] div_abs(input logic [DIV_ABS_W-1:0] val,
                                                     input logic                 neg);
        return neg ? (~val + {{(DIV_ABS_W-1){1'b0}}, 1'b1}) : val;
    endfunction

    function automatic int div_iter(input int width, input int bits);
        return width / bits;
    endfunction

    function automatic int div_cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/cpu_div_stage.sv
// ---------------------------------------------------------------------------
// cpu_div_stage
// One combinational restoring-division step.
// Ports:
//   rem_i   : partial remainder entering the step (always < denom_i)
//   bit_i   : next numerator bit, consumed MSB first
//   denom_i : divisor magnitude
//   rem_o   : partial remainder leaving the step
//   q_o     : quotient bit produced by this step
// ---------------------------------------------------------------------------
module cpu_div_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] denom_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The shifted remainder is kept one bit wider so divisors with the MSB
    // set still compare correctly. Whichever value is selected is below the
    // divisor, so it always fits back into WIDTH bits and the subtraction
    // can be done modulo 2^WIDTH.
    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, denom_i});
    assign diff    = shifted[WIDTH-1:0] - denom_i;
    assign rem_o   = q_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/cpu_divider_radix.sv
// ---------------------------------------------------------------------------
// cpu_divider_radix
// Iterative integer divider for the execute stage. Retires BITS_PER_CYCLE
// quotient bits per clock, handles signed/unsigned operands and returns the
// quotient or the remainder. Results are held until acknowledged; an abort
// (pipeline flush) kills the op in flight or the held result.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   div_ready       : idle, a start is honoured this cycle
//   p3_div_start    : start pulse (ignored unless div_ready)
//   p3_numerator    : dividend
//   p3_denominator  : divisor
//   p3_div_signed   : operands are two's complement
//   p3_div_mod      : 0 = quotient, 1 = remainder
//   p3_latent_dest  : destination tag echoed with the result
//   div_abort       : flush, returns to idle next edge
//   div_valid       : div_result / div_dest_reg valid, held until div_ack
//   div_ack         : pipeline took the result
//   div_result      : quotient or remainder, zero unless div_valid
//   div_dest_reg    : tag captured at start, zero unless div_valid
// ---------------------------------------------------------------------------
module cpu_divider_radix
    import cpu_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int DEST_W         = 5
) (
    input  logic              clock,
    input  logic              reset,
    output logic              div_ready,
    input  logic              p3_div_start,
    input  logic [WIDTH-1:0]  p3_numerator,
    input  logic [WIDTH-1:0]  p3_denominator,
    input  logic              p3_div_signed,
    input  logic              p3_div_mod,
    input  logic [DEST_W-1:0] p3_latent_dest,
    input  logic              div_abort,
    output logic              div_valid,
    input  logic              div_ack,
    output logic [WIDTH-1:0]  div_result,
    output logic [DEST_W-1:0] div_dest_reg
);

    localparam int               ITER     = div_iter(WIDTH, BITS_PER_CYCLE);
    localparam int               CNT_W    = div_cnt_w(ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

    div_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    num_q;
    logic [WIDTH-1:0]    den_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quo_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic                mod_q;
    logic [DEST_W-1:0]   tag_q;
    logic                ready_q;
    logic                valid_q;
    logic [WIDTH-1:0]    result_q;
    logic [DEST_W-1:0]   dest_q;

    logic                num_neg;
    logic                den_neg;
    logic                den_zero;
    logic                sgn_ovf;
    logic [WIDTH-1:0]    num_abs;
    logic [WIDTH-1:0]    den_abs;
    logic [WIDTH-1:0]    fix_quo;
    logic [WIDTH-1:0]    fix_rem;
    logic [WIDTH-1:0]    fix_result;

    logic [WIDTH-1:0]          chain_rem [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] step_bits;

    // Operand classification at start: magnitudes, divide-by-zero and the
    // one signed quotient that does not fit (MIN / -1).
    assign num_neg  = p3_div_signed & p3_numerator[WIDTH-1];
    assign den_neg  = p3_div_signed & p3_denominator[WIDTH-1];
    assign den_zero = (p3_denominator == '0);
    assign sgn_ovf  = p3_div_signed && (p3_numerator == MIN_VAL) && (p3_denominator == ONES);
    assign num_abs  = WIDTH'(div_abs(DIV_ABS_W'(p3_numerator), num_neg));
    assign den_abs  = WIDTH'(div_abs(DIV_ABS_W'(p3_denominator), den_neg));

    // Restoring stages chained within one clock; stage 0 takes the most
    // significant pending numerator bit and produces the most significant
    // quotient bit of this iteration.
    assign chain_rem[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_stage
        cpu_div_stage #(.WIDTH(WIDTH)) u_stage (
            .rem_i   (chain_rem[k]),
            .bit_i   (num_q[WIDTH-1-k]),
            .denom_i (den_q),
            .rem_o   (chain_rem[k+1]),
            .q_o     (step_bits[BITS_PER_CYCLE-1-k])
        );
    end

    // Sign correction applied once in FIXUP. Special cases preload quo/rem
    // with the final answer and clear both sign flags, so they share this path.
    assign fix_quo    = WIDTH'(div_abs(DIV_ABS_W'(quo_q), q_neg_q));
    assign fix_rem    = WIDTH'(div_abs(DIV_ABS_W'(rem_q), r_neg_q));
    assign fix_result = mod_q ? fix_rem : fix_quo;

    // Divider FSM and datapath. Abort dominates everything except reset and
    // drops both the op in flight and any held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            mod_q    <= 1'b0;
            tag_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
        end else if (div_abort) begin
            state_q  <= DIV_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (p3_div_start) begin
                        ready_q <= 1'b0;
                        tag_q   <= p3_latent_dest;
                        mod_q   <= p3_div_mod;
                        cnt_q   <= CNT_LOAD;
                        if (den_zero) begin
                            quo_q   <= ONES;
                            rem_q   <= p3_numerator;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                            state_q <= DIV_FIXUP;
                        end else if (sgn_ovf) begin
                            quo_q   <= MIN_VAL;
                            rem_q   <= '0;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                            state_q <= DIV_FIXUP;
                        end else begin
                            num_q   <= num_abs;
                            den_q   <= den_abs;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            q_neg_q <= num_neg ^ den_neg;
                            r_neg_q <= num_neg;
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= chain_rem[BITS_PER_CYCLE];
                    quo_q <= {quo_q[WIDTH-BITS_PER_CYCLE-1:0], step_bits};
                    num_q <= num_q << BITS_PER_CYCLE;
                    if (cnt_q == '0) begin
                        state_q <= DIV_FIXUP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV_FIXUP: begin
                    result_q <= fix_result;
                    dest_q   <= tag_q;
                    valid_q  <= 1'b1;
                    state_q  <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (div_ack) begin
                        valid_q  <= 1'b0;
                        ready_q  <= 1'b1;
                        result_q <= '0;
                        dest_q   <= '0;
                        state_q  <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A start while busy is a pipeline protocol slip; it is recorded as a
    // coverage event and otherwise ignored by the FSM.
    cover property (@(posedge clock) disable iff (reset) p3_div_start && !ready_q);

    assign div_ready    = ready_q;
    assign div_valid    = valid_q;
    assign div_result   = result_q;
    assign div_dest_reg = dest_q;

endmodule
